// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared result-path constants, word layout and packer state type
package fractal_pkg;

    localparam logic [15:0] RESULT_PAD         = 16'hFFFF;
    localparam logic [15:0] RESULT_TRAILER_TAG = 16'hEEEE;

    // Result word layout; HPS software headers are generated from these
    localparam int FIELD_BITS      = 16;
    localparam int HDR_TILE_ID_LSB = 16;
    localparam int HDR_PIXELS_LSB  = 0;
    localparam int DATA_HI_LSB     = 16;
    localparam int DATA_LO_LSB     = 0;
    localparam int TRL_TAG_LSB     = 16;
    localparam int TRL_SUM_LSB     = 0;

    typedef enum logic [2:0] {
        PK_IDLE,
        PK_HDR,
        PK_LO,
        PK_HI,
        PK_PUSH,
        PK_TRL
    } packer_state_t;

endpackage

// File: rtl/solver_result_packer.sv
// rtl/solver_result_packer.sv - packs iteration counts into header/pair/trailer FIFO words
// Optional trailer with checksum is enabled by defining RESULT_CHECKSUM_EN.
module solver_result_packer
    import fractal_pkg::*;
#(
    parameter int ITER_BITS    = 16,
    parameter int TILE_ID_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    tile_start,
    input  logic [TILE_ID_BITS-1:0] tile_id,
    input  logic [15:0]             tile_pixels,
    input  logic                    res_valid,
    input  logic [ITER_BITS-1:0]    res_iter,
    output logic                    res_ready,
    output logic                    fifo_write,
    output logic [31:0]             fifo_writedata,
    input  logic                    fifo_full,
    output logic                    busy,
    output logic                    tile_done,
    output logic                    start_drop
);

    packer_state_t state_q, state_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [31:0]   data_q, data_d;
    logic          fifo_write_q, fifo_write_d;
    logic          res_ready_q, res_ready_d;
    logic          busy_q, busy_d;
    logic          tile_done_q, tile_done_d;
    logic          start_drop_q, start_drop_d;
    logic          accept;
    logic          handshake;
    logic [15:0]   iter16;
`ifdef RESULT_CHECKSUM_EN
    logic [15:0]   sum_q, sum_d;
`endif

    assign accept    = fifo_write_q && !fifo_full;
    assign handshake = res_ready_q && res_valid;
    assign iter16    = 16'(res_iter);

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        data_d       = data_q;
        start_drop_d = start_drop_q || (tile_start && busy_q);
`ifdef RESULT_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            PK_IDLE: begin
                if (tile_start) begin
                    remaining_d = tile_pixels;
                    data_d[HDR_TILE_ID_LSB +: FIELD_BITS] = 16'(tile_id);
                    data_d[HDR_PIXELS_LSB  +: FIELD_BITS] = tile_pixels;
`ifdef RESULT_CHECKSUM_EN
                    sum_d = 16'h0000;
`endif
                    state_d = PK_HDR;
                end
            end
            PK_HDR, PK_PUSH: begin
                if (accept) begin
                    if (remaining_q != 16'd0) begin
                        state_d = PK_LO;
                    end else begin
`ifdef RESULT_CHECKSUM_EN
                        // All results are already summed by the time the last word leaves
                        data_d[TRL_TAG_LSB +: FIELD_BITS] = RESULT_TRAILER_TAG;
                        data_d[TRL_SUM_LSB +: FIELD_BITS] = sum_q;
                        state_d = PK_TRL;
`else
                        state_d = PK_IDLE;
`endif
                    end
                end
            end
            PK_LO: begin
                if (handshake) begin
                    data_d[DATA_LO_LSB +: FIELD_BITS] = iter16;
                    remaining_d = remaining_q - 16'd1;
`ifdef RESULT_CHECKSUM_EN
                    sum_d = sum_q + iter16;
`endif
                    if (remaining_q == 16'd1) begin
                        data_d[DATA_HI_LSB +: FIELD_BITS] = RESULT_PAD;
                        state_d = PK_PUSH;
                    end else begin
                        state_d = PK_HI;
                    end
                end
            end
            PK_HI: begin
                if (handshake) begin
                    data_d[DATA_HI_LSB +: FIELD_BITS] = iter16;
                    remaining_d = remaining_q - 16'd1;
`ifdef RESULT_CHECKSUM_EN
                    sum_d = sum_q + iter16;
`endif
                    state_d = PK_PUSH;
                end
            end
`ifdef RESULT_CHECKSUM_EN
            PK_TRL: begin
                if (accept) begin
                    state_d = PK_IDLE;
                end
            end
`endif
            default: state_d = PK_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the block registered
        fifo_write_d = (state_d == PK_HDR) || (state_d == PK_PUSH) || (state_d == PK_TRL);
        res_ready_d  = (state_d == PK_LO) || (state_d == PK_HI);
        busy_d       = (state_d != PK_IDLE);
        tile_done_d  = (state_q != PK_IDLE) && (state_d == PK_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PK_IDLE;
            remaining_q  <= 16'd0;
            data_q       <= 32'd0;
            fifo_write_q <= 1'b0;
            res_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            tile_done_q  <= 1'b0;
            start_drop_q <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            sum_q        <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            data_q       <= data_d;
            fifo_write_q <= fifo_write_d;
            res_ready_q  <= res_ready_d;
            busy_q       <= busy_d;
            tile_done_q  <= tile_done_d;
            start_drop_q <= start_drop_d;
`ifdef RESULT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign fifo_write     = fifo_write_q;
    assign fifo_writedata = data_q;
    assign res_ready      = res_ready_q;
    assign busy           = busy_q;
    assign tile_done      = tile_done_q;
    assign start_drop     = start_drop_q;

endmodule

// File: tb/tb_solver_result_packer.sv
// tb/tb_solver_result_packer.sv - randomized self-checking bench with a word-list reference model
`timescale 1ns/1ps
module tb_solver_result_packer;

`ifdef RESULT_CHECKSUM_EN
    localparam int NTRL = 1;
`else
    localparam int NTRL = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tile_start = 1'b0;
    logic [15:0] tile_id = 16'd0;
    logic [15:0] tile_pixels = 16'd0;
    logic        res_valid = 1'b0;
    logic [15:0] res_iter = 16'd0;
    logic        res_ready;
    logic        fifo_write;
    logic [31:0] fifo_writedata;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic        tile_done;
    logic        start_drop;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    bit          exp_last[$];
    logic [31:0] got_log[$];
    logic [15:0] res_arr[0:63];
    logic [31:0] lit[0:3];
    bit          mon_en = 1'b0;
    bit          done_pend = 1'b0;
    bit          exp_drop = 1'b0;
    bit          drop_pend = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    int          wr_cnt = 0;
    int          tiles_completed = 0;

    solver_result_packer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .tile_start     (tile_start),
        .tile_id        (tile_id),
        .tile_pixels    (tile_pixels),
        .res_valid      (res_valid),
        .res_iter       (res_iter),
        .res_ready      (res_ready),
        .fifo_write     (fifo_write),
        .fifo_writedata (fifo_writedata),
        .fifo_full      (fifo_full),
        .busy           (busy),
        .tile_done      (tile_done),
        .start_drop     (start_drop)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a tile is a header, ceil(N/2) pairs padded with FFFF, then an optional trailer
    task automatic build_expected(input logic [15:0] id, input int n);
        logic [15:0] sum = 16'd0;
        logic [15:0] hi;
        exp_q.push_back({id, 16'(n)});
        exp_last.push_back(n == 0 && NTRL == 0);
        for (int i = 0; i < n; i += 2) begin
            sum += res_arr[i];
            if (i + 1 < n) begin
                hi = res_arr[i+1];
                sum += res_arr[i+1];
            end else begin
                hi = 16'hFFFF;
            end
            exp_q.push_back({hi, res_arr[i]});
            exp_last.push_back((i + 2 >= n) && NTRL == 0);
        end
        if (NTRL == 1) begin
            exp_q.push_back({16'hEEEE, sum});
            exp_last.push_back(1'b1);
        end
    endtask

    task automatic chk_log(input int cnt);
        chk("log_len", 32'(got_log.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < got_log.size(); i++)
            chk("log_word", got_log[i], lit[i]);
    endtask

    initial begin : monitor
        logic [31:0] w;
        forever begin
            @(negedge clock);
            #2;
            if (!mon_en) begin
                prev_stall = 1'b0;
                done_pend  = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_write_held", 32'(fifo_write), 32'd1);
                    chk("stall_data_stable", fifo_writedata, prev_data);
                end
                chk("tile_done", 32'(tile_done), 32'(done_pend));
                if (done_pend) tiles_completed++;
                done_pend = 1'b0;
                chk("start_drop", 32'(start_drop), 32'(exp_drop));
                exp_drop = exp_drop | drop_pend;
                chk("ready_write_excl", 32'(res_ready & fifo_write), 32'd0);
                if (fifo_write && !fifo_full) begin
                    wr_cnt++;
                    got_log.push_back(fifo_writedata);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", fifo_writedata, 32'hFFFF_FFFF ^ fifo_writedata);
                    end else begin
                        w = exp_q.pop_front();
                        done_pend = exp_last.pop_front();
                        chk("word", fifo_writedata, w);
                    end
                end
                prev_stall = fifo_write && fifo_full;
                prev_data  = fifo_writedata;
            end
        end
    end

    // mode: 0 normal, 1 second start during HI, 2 reset during PUSH, 3 hold fifo_full for 5 cycles in PUSH
    task automatic run_tile(input logic [15:0] id, input int n, input int vprob, input int fprob,
                            input int mode, input bit preset);
        int idx = 0;
        int cyc = 0;
        int start_done;
        int hold_left = 0;
        int wr_snap = 0;
        bit held = 0;
        bit snap_done = 0;
        bit dropped = 0;
        if (!preset)
            for (int i = 0; i < n; i++) res_arr[i] = 16'($urandom);
        build_expected(id, n);
        got_log.delete();
        start_done = tiles_completed;
        @(negedge clock);
        tile_id = id;
        tile_pixels = 16'(n);
        tile_start = 1'b1;
        res_valid = 1'b0;
        fifo_full = 1'b0;
        @(negedge clock);
        tile_start = 1'b0;
        chk("hdr_latency", 32'(fifo_write), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        while (tiles_completed == start_done) begin
            if (cyc >= 3000) begin
                chk("tile_timeout", 32'd0, 32'd1);
                break;
            end
            res_iter  = (idx < n) ? res_arr[idx] : 16'd0;
            res_valid = (idx < n) && ($urandom_range(0, 99) < vprob);
            fifo_full = ($urandom_range(0, 99) < fprob);
            tile_start = 1'b0;
            if (held && hold_left == 0 && !snap_done) begin
                chk("hold_no_accept", 32'(wr_cnt), 32'(wr_snap));
                snap_done = 1'b1;
            end
            if (mode == 3 && !held && fifo_write && idx >= 2) begin
                held = 1'b1;
                hold_left = 5;
                wr_snap = wr_cnt;
            end
            if (hold_left > 0) begin
                fifo_full = 1'b1;
                chk("hold_no_ready", 32'(res_ready), 32'd0);
                chk("hold_write", 32'(fifo_write), 32'd1);
                hold_left--;
            end
            if (mode == 1 && !dropped && res_ready && (idx % 2 == 1)) begin
                tile_start = 1'b1;
                tile_id = ~id;
                tile_pixels = 16'd7;
                dropped = 1'b1;
                drop_pend = 1'b1;
            end
            if (mode == 2 && fifo_write && idx >= 2 && idx < n) begin
                mon_en = 1'b0;
                fifo_full = 1'b1;
                res_valid = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("rst_fifo_write", 32'(fifo_write), 32'd0);
                chk("rst_writedata", fifo_writedata, 32'd0);
                chk("rst_res_ready", 32'(res_ready), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_start_drop", 32'(start_drop), 32'd0);
                @(negedge clock);
                reset_n = 1'b1;
                exp_q.delete();
                exp_last.delete();
                exp_drop = 1'b0;
                drop_pend = 1'b0;
                fifo_full = 1'b0;
                @(negedge clock);
                mon_en = 1'b1;
                return;
            end
            if (res_valid && res_ready) idx++;
            @(negedge clock);
            cyc++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        res_valid = 1'b0;
        fifo_full = 1'b0;
        tile_start = 1'b0;
    endtask

    initial begin : stimulus
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_fifo_write", 32'(fifo_write), 32'd0);
        chk("reset_writedata", fifo_writedata, 32'd0);
        chk("reset_res_ready", 32'(res_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tile_done", 32'(tile_done), 32'd0);
        chk("reset_start_drop", 32'(start_drop), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) res_arr[i] = 16'(i + 1);
        run_tile(16'h0012, 4, 100, 0, 0, 1'b1);
        lit[0] = 32'h00120004; lit[1] = 32'h00020001; lit[2] = 32'h00040003; lit[3] = 32'hEEEE000A;
        chk_log(3 + NTRL);

        for (int i = 0; i < 3; i++) res_arr[i] = 16'(i + 5);
        run_tile(16'h0012, 3, 100, 0, 0, 1'b1);
        lit[0] = 32'h00120003; lit[1] = 32'h00060005; lit[2] = 32'hFFFF0007; lit[3] = 32'hEEEE0012;
        chk_log(3 + NTRL);

        run_tile(16'h0012, 0, 100, 0, 0, 1'b1);
        lit[0] = 32'h00120000; lit[1] = 32'hEEEE0000;
        chk_log(1 + NTRL);

        run_tile(16'h0A0B, 6, 100, 0, 3, 1'b0);
        run_tile(16'h0C0D, 8, 80, 20, 1, 1'b0);
        chk("drop_sticky", 32'(start_drop), 32'd1);
        run_tile(16'h0E0F, 5, 90, 10, 0, 1'b0);
        chk("drop_still_sticky", 32'(start_drop), 32'd1);
        run_tile(16'h0101, 9, 100, 0, 2, 1'b0);

        res_arr[0] = 16'd9; res_arr[1] = 16'd10;
        run_tile(16'h0034, 2, 100, 0, 0, 1'b1);
        lit[0] = 32'h00340002; lit[1] = 32'h000A0009; lit[2] = 32'hEEEE0013;
        chk_log(2 + NTRL);

        for (int t = 0; t < 12; t++)
            run_tile(16'($urandom), int'($urandom_range(0, 25)), int'($urandom_range(30, 100)),
                     int'($urandom_range(0, 60)), 0, 1'b0);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
